// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm sequencer.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } alarm_state_t;

  localparam int DEF_RING_TIMEOUT = 60;
  localparam int DEF_SNOOZE_SEC   = 300;
  localparam int DEF_MAX_SNOOZE   = 3;

endpackage

// File: rtl/alarm_sequencer_if.sv
// Time, button and tone-gate signals between the timekeeper side and the
// alarm sequencer. master drives time/buttons, slave is the sequencer.
interface alarm_sequencer_if;
  logic       sec_tick;
  logic [3:0] hourdec_now;
  logic [3:0] hourone_now;
  logic [3:0] mindec_now;
  logic [3:0] minone_now;
  logic [3:0] hourdec_bud;
  logic [3:0] hourone_bud;
  logic [3:0] mindec_bud;
  logic [3:0] minone_bud;
  logic       bud_en;
  logic       off_bud;
  logic       snooze_btn;
  logic       ring;
  logic       tone_on;
  logic       snoozing;
  logic [1:0] snooze_cnt;

  modport master (
    output sec_tick,
    output hourdec_now, hourone_now, mindec_now, minone_now,
    output hourdec_bud, hourone_bud, mindec_bud, minone_bud,
    output bud_en, off_bud, snooze_btn,
    input  ring, tone_on, snoozing, snooze_cnt
  );

  modport slave (
    input  sec_tick,
    input  hourdec_now, hourone_now, mindec_now, minone_now,
    input  hourdec_bud, hourone_bud, mindec_bud, minone_bud,
    input  bud_en, off_bud, snooze_btn,
    output ring, tone_on, snoozing, snooze_cnt
  );
endinterface

// File: rtl/alarm_sequencer_rise_detect.sv
// Registered copy of a synchronous level plus a one-cycle rising-edge pulse.
module rise_detect (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Delay the level by one cycle for edge comparison.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d && !d_q;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze controller. Starts ringing on entry into the minute that
// matches the alarm time, times out the ring, and gates the tone generator.
// Optional feature macro: ALARM_SNOOZE_EN enables the snooze state, its
// counters and the snooze button; without it snoozing/snooze_cnt read 0.
//
// state   | meaning
// IDLE    | waiting for the current time to enter the alarm minute
// RINGING | alarm sounding, tone gated 1 s on / 1 s off
// SNOOZE  | alarm silenced, counting down to the next ring
import alarm_pkg::*;

module alarm_sequencer #(
  parameter int RING_TIMEOUT = DEF_RING_TIMEOUT,
  parameter int SNOOZE_SEC   = DEF_SNOOZE_SEC,
  parameter int MAX_SNOOZE   = DEF_MAX_SNOOZE
) (
  input logic               clk,
  input logic               rstn,
  alarm_sequencer_if.slave  bus
);

  localparam int RW = $clog2(RING_TIMEOUT + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT - 1);

  alarm_state_t  state, state_nxt;
  logic [RW-1:0] ring_secs, ring_secs_nxt;
  logic          match, match_q, trigger;
  logic          off_edge;

  assign match = bus.bud_en
              && (bus.hourdec_now == bus.hourdec_bud)
              && (bus.hourone_now == bus.hourone_bud)
              && (bus.mindec_now  == bus.mindec_bud)
              && (bus.minone_now  == bus.minone_bud);

  // Reset to 1 so a time already matching at reset release does not ring.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) match_q <= 1'b1;
    else       match_q <= match;
  end

  assign trigger = match && !match_q;

  rise_detect u_off_rise (
    .clk  (clk),
    .rstn (rstn),
    .d    (bus.off_bud),
    .rise (off_edge)
  );

`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  localparam int CW = $clog2(MAX_SNOOZE + 1);
  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_SEC - 1);
  localparam logic [CW-1:0] SNZ_LIMIT   = CW'(MAX_SNOOZE);

  logic [SW-1:0] snooze_secs, snooze_secs_nxt;
  logic [CW-1:0] snooze_cnt, snooze_cnt_nxt;
  logic          snooze_edge;

  rise_detect u_snooze_rise (
    .clk  (clk),
    .rstn (rstn),
    .d    (bus.snooze_btn),
    .rise (snooze_edge)
  );
`else
  logic unused_snooze_btn;
  localparam int UNUSED_SNOOZE_CFG = SNOOZE_SEC + MAX_SNOOZE;
  assign unused_snooze_btn = bus.snooze_btn;
`endif

  // State and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      ring_secs   <= '0;
`ifdef ALARM_SNOOZE_EN
      snooze_secs <= '0;
      snooze_cnt  <= '0;
`endif
    end else begin
      state       <= state_nxt;
      ring_secs   <= ring_secs_nxt;
`ifdef ALARM_SNOOZE_EN
      snooze_secs <= snooze_secs_nxt;
      snooze_cnt  <= snooze_cnt_nxt;
`endif
    end
  end

  // Next state: bud_en low > off edge > snooze edge > sec_tick.
  always_comb begin
    state_nxt       = state;
    ring_secs_nxt   = ring_secs;
`ifdef ALARM_SNOOZE_EN
    snooze_secs_nxt = snooze_secs;
    snooze_cnt_nxt  = snooze_cnt;
`endif
    case (state)
      IDLE: begin
        if (trigger) begin
          state_nxt     = RINGING;
          ring_secs_nxt = '0;
        end
      end
      RINGING: begin
        if (off_edge) begin
          state_nxt = IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze_edge) begin
          // A press at the snooze limit is dropped, and so is any tick with it.
          if (snooze_cnt < SNZ_LIMIT) begin
            state_nxt       = SNOOZE;
            snooze_secs_nxt = SNOOZE_LOAD;
            snooze_cnt_nxt  = snooze_cnt + CW'(1);
          end
`endif
        end else if (bus.sec_tick) begin
          if (ring_secs == RING_LAST) state_nxt = IDLE;
          else                        ring_secs_nxt = ring_secs + RW'(1);
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (off_edge) begin
          state_nxt = IDLE;
        end else if (snooze_edge) begin
          state_nxt = SNOOZE;
        end else if (bus.sec_tick) begin
          if (snooze_secs == '0) begin
            state_nxt     = RINGING;
            ring_secs_nxt = '0;
          end else begin
            snooze_secs_nxt = snooze_secs - SW'(1);
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase

    if (!bus.bud_en) state_nxt = IDLE;

    if (state_nxt == IDLE) begin
      ring_secs_nxt   = '0;
`ifdef ALARM_SNOOZE_EN
      snooze_secs_nxt = '0;
      snooze_cnt_nxt  = '0;
`endif
    end
  end

  assign bus.ring    = (state == RINGING);
  assign bus.tone_on = (state == RINGING) && !ring_secs[0];

`ifdef ALARM_SNOOZE_EN
  assign bus.snoozing   = (state == SNOOZE);
  assign bus.snooze_cnt = 2'(snooze_cnt);
`else
  assign bus.snoozing   = 1'b0;
  assign bus.snooze_cnt = 2'b00;
`endif

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer with RING_TIMEOUT=4, SNOOZE_SEC=3,
// MAX_SNOOZE=2. Stimulus pushes expected outputs tagged with the cycle at
// which they must be seen; the monitor pops and compares on each falling edge.
module tb_alarm_sequencer;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  alarm_sequencer_if bus ();

  alarm_sequencer #(
    .RING_TIMEOUT (4),
    .SNOOZE_SEC   (3),
    .MAX_SNOOZE   (2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    int         when;
    string      name;
    logic       ring;
    logic       tone;
    logic       snz;
    logic [1:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    while (sb.size() > 0 && sb[0].when <= cyc) begin
      mon_e  = sb.pop_front();
      checks = checks + 1;
      if (mon_e.when != cyc ||
          {bus.ring, bus.tone_on, bus.snoozing, bus.snooze_cnt} !==
          {mon_e.ring, mon_e.tone, mon_e.snz, mon_e.cnt}) begin
        errors = errors + 1;
        $display("FAIL %s @cyc %0d: ring/tone_on/snoozing/snooze_cnt got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 mon_e.name, cyc, bus.ring, bus.tone_on, bus.snoozing, bus.snooze_cnt,
                 mon_e.ring, mon_e.tone, mon_e.snz, mon_e.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic r, input logic t,
                            input logic s, input logic [1:0] c);
    exp_t e;
    e.when = cyc + 1;
    e.name = nm;
    e.ring = r;
    e.tone = t;
    e.snz  = s;
    e.cnt  = c;
    sb.push_back(e);
  endtask

  task automatic sec();
    bus.sec_tick = 1'b1;
    tick();
    bus.sec_tick = 1'b0;
  endtask

  task automatic press_off();
    bus.off_bud = 1'b1;
    tick();
    bus.off_bud = 1'b0;
  endtask

  task automatic press_snz();
    bus.snooze_btn = 1'b1;
    tick();
    bus.snooze_btn = 1'b0;
  endtask

  task automatic set_min(input logic [3:0] md, input logic [3:0] mo);
    bus.mindec_now = md;
    bus.minone_now = mo;
  endtask

  // Leave the alarm minute, then re-enter it: ringing starts one edge later.
  task automatic ring_up();
    set_min(4'd5, 4'd1);
    tick();
    set_min(4'd5, 4'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn            = 1'b0;
    bus.sec_tick    = 1'b0;
    bus.off_bud     = 1'b0;
    bus.snooze_btn  = 1'b0;
    bus.bud_en      = 1'b1;
    bus.hourdec_now = 4'd1;
    bus.hourone_now = 4'd1;
    bus.mindec_now  = 4'd4;
    bus.minone_now  = 4'd9;
    bus.hourdec_bud = 4'd1;
    bus.hourone_bud = 4'd1;
    bus.mindec_bud  = 4'd5;
    bus.minone_bud  = 4'd0;

    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    expect_out("reset", 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    expect_out("idle_1149", 1'b0, 1'b0, 1'b0, 2'd0);

    set_min(4'd5, 4'd0);
    tick();
    expect_out("ring_start", 1'b1, 1'b1, 1'b0, 2'd0);
    tick();
    expect_out("ring_hold", 1'b1, 1'b1, 1'b0, 2'd0);
    sec();
    expect_out("tone_t1", 1'b1, 1'b0, 1'b0, 2'd0);
    sec();
    expect_out("tone_t2", 1'b1, 1'b1, 1'b0, 2'd0);
    sec();
    expect_out("tone_t3", 1'b1, 1'b0, 1'b0, 2'd0);
    sec();
    expect_out("timeout", 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      sec();
      tick();
    end
    expect_out("no_retrigger", 1'b0, 1'b0, 1'b0, 2'd0);

    ring_up();
    expect_out("retrig", 1'b1, 1'b1, 1'b0, 2'd0);
    sec();
    expect_out("retrig_t1", 1'b1, 1'b0, 1'b0, 2'd0);
    press_off();
    expect_out("off", 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    expect_out("off_hold", 1'b0, 1'b0, 1'b0, 2'd0);

    ring_up();
    expect_out("ring_for_snz", 1'b1, 1'b1, 1'b0, 2'd0);
`ifdef ALARM_SNOOZE_EN
    press_snz();
    expect_out("snz1", 1'b0, 1'b0, 1'b1, 2'd1);
    sec();
    expect_out("snz1_t1", 1'b0, 1'b0, 1'b1, 2'd1);
    sec();
    expect_out("snz1_t2", 1'b0, 1'b0, 1'b1, 2'd1);
    sec();
    expect_out("rering1", 1'b1, 1'b1, 1'b0, 2'd1);
    press_snz();
    expect_out("snz2", 1'b0, 1'b0, 1'b1, 2'd2);
    sec();
    sec();
    expect_out("snz2_t2", 1'b0, 1'b0, 1'b1, 2'd2);
    sec();
    expect_out("rering2", 1'b1, 1'b1, 1'b0, 2'd2);
    press_snz();
    expect_out("snz3_ignored", 1'b1, 1'b1, 1'b0, 2'd2);
    press_off();
    expect_out("off_after_snz", 1'b0, 1'b0, 1'b0, 2'd0);

    ring_up();
    press_snz();
    expect_out("snz_before_drop", 1'b0, 1'b0, 1'b1, 2'd1);
    bus.bud_en = 1'b0;
    tick();
    expect_out("bud_en_drop", 1'b0, 1'b0, 1'b0, 2'd0);
`else
    press_snz();
    expect_out("snz_ignored", 1'b1, 1'b1, 1'b0, 2'd0);
    sec();
    expect_out("snz_ignored_t1", 1'b1, 1'b0, 1'b0, 2'd0);
    bus.bud_en = 1'b0;
    tick();
    expect_out("bud_en_drop", 1'b0, 1'b0, 1'b0, 2'd0);
`endif
    set_min(4'd5, 4'd1);
    bus.bud_en = 1'b1;
    tick();
    expect_out("bud_en_back", 1'b0, 1'b0, 1'b0, 2'd0);

    ring_up();
    expect_out("ring_for_both", 1'b1, 1'b1, 1'b0, 2'd0);
    bus.off_bud    = 1'b1;
    bus.snooze_btn = 1'b1;
    tick();
    bus.off_bud    = 1'b0;
    bus.snooze_btn = 1'b0;
    expect_out("off_and_snz", 1'b0, 1'b0, 1'b0, 2'd0);

    ring_up();
    expect_out("pre_reset", 1'b1, 1'b1, 1'b0, 2'd0);
    tick();
    rstn = 1'b0;
    expect_out("reset_async", 1'b0, 1'b0, 1'b0, 2'd0);
    tick();
    rstn = 1'b1;
    repeat (4) tick();
    expect_out("no_rering", 1'b0, 1'b0, 1'b0, 2'd0);
    ring_up();
    expect_out("refire", 1'b1, 1'b1, 1'b0, 2'd0);

    repeat (2) tick();
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
